// File: rtl/p09_background_engine_if.sv
// Pixel, frame-control and palette-write signals between the timing/control side
// (master) and the background engine (slave).
interface p09_background_engine_if #(
  parameter int HTOTAL     = 800,
  parameter int VTOTAL     = 525,
  parameter int COLOR_W    = 6,
  parameter int NUM_COLORS = 4,
  parameter int TIME_W     = 8
);
  localparam int HW    = $clog2(HTOTAL) + 1;
  localparam int VW    = $clog2(VTOTAL) + 1;
  localparam int IDX_W = $clog2(NUM_COLORS);

  // pix_valid_in qualifies counter_h/counter_v in the same cycle; there is no ready:
  // the engine accepts one pixel every clock and never stalls.
  logic                      frame_tick;
  logic                      pause;
  logic [1:0]                mode_req;
  logic [2:0]                speed_req;
  logic                      pal_we;
  logic [IDX_W-1:0]          pal_addr;
  logic [COLOR_W-1:0]        pal_data;
  logic                      pix_valid_in;
  logic signed [HW-1:0]      counter_h;
  logic signed [VW-1:0]      counter_v;
  logic [TIME_W-1:0]         cur_time;
  logic                      pix_valid_out;
  logic [COLOR_W-1:0]        color_out;

  modport master (
    output frame_tick, pause, mode_req, speed_req, pal_we, pal_addr, pal_data,
           pix_valid_in, counter_h, counter_v,
    input  cur_time, pix_valid_out, color_out
  );

  modport slave (
    input  frame_tick, pause, mode_req, speed_req, pal_we, pal_addr, pal_data,
           pix_valid_in, counter_h, counter_v,
    output cur_time, pix_valid_out, color_out
  );
endinterface

// File: rtl/p09_background_engine.sv
// Background colour engine: frame-latched mode/speed, animation counter, writable
// palette and a two-stage pixel pipeline (compute index, then palette lookup).
module p09_background_engine #(
  parameter int HTOTAL       = 800,
  parameter int VTOTAL       = 525,
  parameter int COLOR_W      = 6,
  parameter int NUM_COLORS   = 4,
  parameter int TIME_W       = 8,
  parameter int STRIPE_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  p09_background_engine_if.slave bus
);
  localparam int HW     = $clog2(HTOTAL) + 1;
  localparam int VW     = $clog2(VTOTAL) + 1;
  localparam int IDX_W  = $clog2(NUM_COLORS);
  localparam int MAX_HV = (HW > VW) ? HW : VW;
  localparam int SUM_W  = ((MAX_HV > TIME_W) ? MAX_HV : TIME_W) + 1;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_XOR     = 2'd1;
  localparam logic [1:0] MODE_DIAG    = 2'd2;
  localparam logic [1:0] MODE_HSTRIPE = 2'd3;

  logic [TIME_W-1:0]  time_q;
  logic [1:0]         mode_q;
  logic [2:0]         speed_q;
  logic [COLOR_W-1:0] palette_q [NUM_COLORS];

  logic               s1_valid_q;
  logic [1:0]         s1_mode_q;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  logic [COLOR_W-1:0] s1_col_q, s1_col_d;
  logic               valid_q;
  logic [COLOR_W-1:0] color_q, color_d;

  // Mode and speed only move on frame_tick so a frame is never drawn with mixed settings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q  <= '0;
      mode_q  <= MODE_SOLID;
      speed_q <= 3'd1;
    end else if (bus.frame_tick) begin
      mode_q  <= bus.mode_req;
      speed_q <= bus.speed_req;
      if (!bus.pause) time_q <= time_q + TIME_W'(speed_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLORS; i++) palette_q[i] <= COLOR_W'(i);
    end else if (bus.pal_we) begin
      palette_q[bus.pal_addr] <= bus.pal_data;
    end
  end

  // Sums are done at SUM_W so negative counters wrap like plain two's complement.
  logic [SUM_W-1:0] h_ext, v_ext, t_ext, diag_sum, hs_sum, diag_shr, hs_shr;
  logic [5:0]       xor_sum;

  always_comb begin
    h_ext    = {{(SUM_W-HW){bus.counter_h[HW-1]}}, bus.counter_h};
    v_ext    = {{(SUM_W-VW){bus.counter_v[VW-1]}}, bus.counter_v};
    t_ext    = {{(SUM_W-TIME_W){1'b0}}, time_q};
    diag_sum = h_ext + v_ext + t_ext;
    hs_sum   = v_ext + t_ext;
    diag_shr = diag_sum >> STRIPE_SHIFT;
    hs_shr   = hs_sum >> (STRIPE_SHIFT - 1);
    xor_sum  = (bus.counter_h[7:2] ^ bus.counter_v[7:2]) + time_q[7:2];
    s1_col_d = COLOR_W'(xor_sum);
    s1_idx_d = '0;
    case (mode_q)
      MODE_DIAG:    s1_idx_d = diag_shr[IDX_W-1:0];
      MODE_HSTRIPE: s1_idx_d = hs_shr[IDX_W-1:0];
      default:      s1_idx_d = '0;
    endcase
  end

  always_comb begin
    color_d = '0;
    if (s1_valid_q) color_d = (s1_mode_q == MODE_XOR) ? s1_col_q : palette_q[s1_idx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_SOLID;
      s1_idx_q   <= '0;
      s1_col_q   <= '0;
      valid_q    <= 1'b0;
      color_q    <= '0;
    end else begin
      s1_valid_q <= bus.pix_valid_in;
      s1_mode_q  <= mode_q;
      s1_idx_q   <= s1_idx_d;
      s1_col_q   <= s1_col_d;
      valid_q    <= s1_valid_q;
      color_q    <= color_d;
    end
  end

  assign bus.cur_time      = time_q;
  assign bus.pix_valid_out = valid_q;
  assign bus.color_out     = color_q;
endmodule

// File: tb/tb_p09_background_engine.sv
// Directed bench for the background engine: reset, diagonal/xor/stripe modes,
// animation counter wrap, palette write race, frame-latched mode and async reset.
module tb_p09_background_engine;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  p09_background_engine_if bus ();

  p09_background_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pix(input int h, input int v, input logic valid);
    bus.counter_h    = 11'(h);
    bus.counter_v    = 11'(v);
    bus.pix_valid_in = valid;
  endtask

  task automatic do_tick(input logic [1:0] mode, input logic [2:0] speed, input logic pause);
    bus.mode_req   = mode;
    bus.speed_req  = speed;
    bus.pause      = pause;
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
  endtask

  task automatic apply_reset();
    bus.frame_tick = 1'b0;
    bus.pause      = 1'b0;
    bus.mode_req   = 2'd0;
    bus.speed_req  = 3'd1;
    bus.pal_we     = 1'b0;
    bus.pal_addr   = '0;
    bus.pal_data   = '0;
    set_pix(0, 0, 1'b0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    set_pix(64, 0, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd0 || bus.pix_valid_out !== 1'b0 || bus.cur_time !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: color=%0h valid=%0b time=%0d, required 0/0/0",
               bus.color_out, bus.pix_valid_out, bus.cur_time);
    end
    reset = 1'b0;
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd0 || bus.pix_valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_solid: color=%0h valid=%0b, required 0/1", bus.color_out, bus.pix_valid_out);
    end
  endtask

  task automatic test_diag();
    int          th [5] = '{0, 64, 64, 192, -64};
    int          tv [5] = '{0, 0, 64, 0, 0};
    logic [5:0]  te [5] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd3};
    apply_reset();
    do_tick(2'd2, 3'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_pix(th[i], tv[i], 1'b1);
      step(2);
      tests_run++;
      if (bus.color_out !== te[i] || bus.pix_valid_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL diag_%0d: color=%0h valid=%0b, required %0h/1",
                 i, bus.color_out, bus.pix_valid_out, te[i]);
      end
    end
  endtask

  task automatic test_time();
    logic [7:0] exp3 [3] = '{8'd1, 8'd4, 8'd7};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_tick(2'd0, 3'd3, 1'b0);
      tests_run++;
      if (bus.cur_time !== exp3[i]) begin
        tests_failed++;
        $display("FAIL time_tick_%0d: time=%0d, required %0d", i, bus.cur_time, exp3[i]);
      end
    end
    do_tick(2'd0, 3'd7, 1'b1);
    tests_run++;
    if (bus.cur_time !== 8'd7) begin
      tests_failed++;
      $display("FAIL time_pause: time=%0d, required 7", bus.cur_time);
    end
    repeat (34) do_tick(2'd0, 3'd7, 1'b0);
    tests_run++;
    if (bus.cur_time !== 8'd245) begin
      tests_failed++;
      $display("FAIL time_245: time=%0d, required 245", bus.cur_time);
    end
    do_tick(2'd0, 3'd2, 1'b0);
    do_tick(2'd0, 3'd7, 1'b0);
    tests_run++;
    if (bus.cur_time !== 8'd254) begin
      tests_failed++;
      $display("FAIL time_254: time=%0d, required 254", bus.cur_time);
    end
    do_tick(2'd0, 3'd7, 1'b0);
    tests_run++;
    if (bus.cur_time !== 8'd5) begin
      tests_failed++;
      $display("FAIL time_wrap: time=%0d, required 5", bus.cur_time);
    end
  endtask

  task automatic test_xor();
    apply_reset();
    do_tick(2'd1, 3'd7, 1'b0);
    set_pix(8, 4, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd3) begin
      tests_failed++;
      $display("FAIL xor_t1: color=%0h, required 3", bus.color_out);
    end
    do_tick(2'd1, 3'd7, 1'b0);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd5 || bus.cur_time !== 8'd8) begin
      tests_failed++;
      $display("FAIL xor_t8: color=%0h time=%0d, required 5/8", bus.color_out, bus.cur_time);
    end
    set_pix(-4, 0, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd1) begin
      tests_failed++;
      $display("FAIL xor_neg: color=%0h, required 1", bus.color_out);
    end
  endtask

  task automatic test_palette_race();
    apply_reset();
    do_tick(2'd2, 3'd1, 1'b1);
    set_pix(128, 0, 1'b1);
    step(1);
    bus.pal_we   = 1'b1;
    bus.pal_addr = 2'd2;
    bus.pal_data = 6'h3F;
    step(1);
    bus.pal_we = 1'b0;
    tests_run++;
    if (bus.color_out !== 6'd2) begin
      tests_failed++;
      $display("FAIL pal_old: color=%0h, required 2", bus.color_out);
    end
    step(1);
    tests_run++;
    if (bus.color_out !== 6'h3F) begin
      tests_failed++;
      $display("FAIL pal_new: color=%0h, required 3f", bus.color_out);
    end
  endtask

  task automatic test_mode_latch();
    apply_reset();
    do_tick(2'd2, 3'd1, 1'b1);
    set_pix(0, 32, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL latch_diag: color=%0h, required 0", bus.color_out);
    end
    bus.mode_req = 2'd3;
    step(3);
    tests_run++;
    if (bus.color_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL latch_no_tick: color=%0h, required 0", bus.color_out);
    end
    do_tick(2'd3, 3'd1, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd1) begin
      tests_failed++;
      $display("FAIL latch_hstripe: color=%0h, required 1", bus.color_out);
    end
    set_pix(0, 32, 1'b0);
    step(1);
    tests_run++;
    if (bus.color_out !== 6'd1 || bus.pix_valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL blank_latency: color=%0h valid=%0b, required 1/1", bus.color_out, bus.pix_valid_out);
    end
    step(1);
    tests_run++;
    if (bus.color_out !== 6'd0 || bus.pix_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL blank: color=%0h valid=%0b, required 0/0", bus.color_out, bus.pix_valid_out);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_tick(2'd2, 3'd3, 1'b0);
    bus.pal_we   = 1'b1;
    bus.pal_addr = 2'd0;
    bus.pal_data = 6'h2A;
    step(1);
    bus.pal_we = 1'b0;
    set_pix(0, 0, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'h2A || bus.cur_time !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_pre: color=%0h time=%0d, required 2a/1", bus.color_out, bus.cur_time);
    end
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.color_out !== 6'd0 || bus.pix_valid_out !== 1'b0 || bus.cur_time !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_async: color=%0h valid=%0b time=%0d, required 0/0/0",
               bus.color_out, bus.pix_valid_out, bus.cur_time);
    end
    step(1);
    reset = 1'b0;
    set_pix(64, 0, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd0 || bus.pix_valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_recover: color=%0h valid=%0b, required 0/1", bus.color_out, bus.pix_valid_out);
    end
    bus.pal_we   = 1'b0;
    do_tick(2'd2, 3'd1, 1'b1);
    step(2);
    tests_run++;
    if (bus.color_out !== 6'd1) begin
      tests_failed++;
      $display("FAIL mid_palette: color=%0h, required 1", bus.color_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    test_reset();
    test_diag();
    test_time();
    test_xor();
    test_palette_race();
    test_mode_latch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
